// File: rtl/int_arbiter_if.sv
// Bus bundle between the interrupt arbiter and its surroundings: raw source
// lines, Core acknowledge, the small register port and the request outputs.
//
// Handshake: there is no valid/ready pair on this port. reg_we is a one-cycle
// write strobe qualified by reg_addr/reg_wdata on the same rising edge.
// int_ack is a one-cycle pulse, honoured only when the arbiter is idle and has
// an eligible source. reg_rdata is combinational from reg_addr, with no strobe.
interface int_arbiter_if #(
  parameter int NSRC = 4
);
  logic [NSRC-1:0] src_irq;
  logic            int_ack;
  logic            reg_we;
  logic [1:0]      reg_addr;
  logic [31:0]     reg_wdata;
  logic [31:0]     reg_rdata;
  logic            out_interruption;
  logic [3:0]      active_id;
  logic            dbg_state;   // 0 = IDLE, 1 = SERVICE

  modport slave (
    input  src_irq, int_ack, reg_we, reg_addr, reg_wdata,
    output reg_rdata, out_interruption, active_id, dbg_state
  );

  modport master (
    output src_irq, int_ack, reg_we, reg_addr, reg_wdata,
    input  reg_rdata, out_interruption, active_id, dbg_state
  );
endinterface

// File: rtl/int_arbiter.sv
// Fixed-priority interrupt arbiter. Raw lines are synchronised and
// edge-detected, latched as pending, masked, and the lowest enabled index is
// handed to the Core on acknowledge. There is no nesting: one source is in
// service until software writes EOI.
module int_arbiter #(
  parameter int NSRC        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         resetn,
  int_arbiter_if.slave bus
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_SERVICE = 1'b1
  } state_t;

  localparam logic [1:0] ADDR_MASK    = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_ID      = 2'd2;
  localparam logic [1:0] ADDR_EOI     = 2'd3;

  logic [SYNC_STAGES-1:0][NSRC-1:0] sync_q;
  logic [NSRC-1:0] prev_q;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] w1c_clr;
  logic [NSRC-1:0] ack_clr;
  logic [2:0]      winner;
  logic            any_eligible;
  logic            mask_wr, pend_wr, eoi_wr;
  logic            ack_take;
  state_t          state_q;
  logic            out_int_q;
  logic [3:0]      active_id_q;
  logic [31:0]     rdata;

  // Synchroniser chain plus one extra flop holding the previous synced value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= bus.src_irq;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Rising edges only; a line held high produces exactly one event.
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  assign mask_wr = bus.reg_we && (bus.reg_addr == ADDR_MASK);
  assign pend_wr = bus.reg_we && (bus.reg_addr == ADDR_PENDING);
  assign eoi_wr  = bus.reg_we && (bus.reg_addr == ADDR_EOI);

  assign eligible     = pending_q & mask_q;
  assign any_eligible = |eligible;

  // Lowest set index wins; scanning downwards leaves the smallest one.
  always_comb begin
    winner = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 3'(i);
    end
  end

  // EOI takes precedence over a same-cycle acknowledge.
  assign ack_take = bus.int_ack && (state_q == ST_IDLE) && any_eligible && !eoi_wr;

  // Next pending/mask values; a fresh edge beats any clear in the same cycle.
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      ack_clr[i] = ack_take && (winner == 3'(i));
    end
    w1c_clr   = pend_wr ? bus.reg_wdata[NSRC-1:0] : '0;
    pending_d = (pending_q & ~(w1c_clr | ack_clr)) | rise;
    mask_d    = mask_wr ? bus.reg_wdata[NSRC-1:0] : mask_q;
  end

  // Pending and mask registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  // Service FSM with registered request and active id.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      out_int_q   <= 1'b0;
      active_id_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (eoi_wr) begin
            active_id_q <= '0;
          end
          if (ack_take) begin
            state_q     <= ST_SERVICE;
            active_id_q <= {1'b1, winner};
            out_int_q   <= 1'b0;
          end else begin
            out_int_q <= any_eligible;
          end
        end
        ST_SERVICE: begin
          // Request stays low; it is re-evaluated from IDLE one edge after EOI.
          out_int_q <= 1'b0;
          if (eoi_wr) begin
            state_q     <= ST_IDLE;
            active_id_q <= '0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_int_q   <= 1'b0;
          active_id_q <= '0;
        end
      endcase
    end
  end

  // Combinational register read mux; ID write is a no-op and EOI reads 0.
  always_comb begin
    rdata = '0;
    case (bus.reg_addr)
      ADDR_MASK:    rdata[NSRC-1:0] = mask_q;
      ADDR_PENDING: rdata[NSRC-1:0] = pending_q;
      ADDR_ID:      rdata[4:0]      = {active_id_q[3], 1'b0, active_id_q[2:0]};
      default:      rdata           = '0;
    endcase
  end

  assign bus.reg_rdata        = rdata;
  assign bus.out_interruption = out_int_q;
  assign bus.active_id        = active_id_q;
  assign bus.dbg_state        = state_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Directed bench for int_arbiter (NSRC=4, SYNC_STAGES=2). Inputs change 1 time
// unit after a rising edge; outputs are sampled at that same offset.
module tb_int_arbiter;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_errors;

  int_arbiter_if #(.NSRC(4)) bus ();

  int_arbiter #(
    .NSRC(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus.slave)
  );

  // Clock: period 20.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    bus.reg_addr = addr;
    #1;
    check(tag, bus.reg_rdata, exp);
  endtask

  task automatic reg_wr(input logic [1:0] addr, input logic [31:0] data);
    bus.reg_we    = 1'b1;
    bus.reg_addr  = addr;
    bus.reg_wdata = data;
    tick();
    bus.reg_we    = 1'b0;
    bus.reg_wdata = '0;
  endtask

  task automatic ack();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    resetn        = 1'b0;
    bus.src_irq   = '0;
    bus.int_ack   = 1'b0;
    bus.reg_we    = 1'b0;
    bus.reg_addr  = '0;
    bus.reg_wdata = '0;

    // Reset state
    repeat (3) tick();
    check("rst_out", bus.out_interruption, 0);
    check("rst_active", bus.active_id, 0);
    check("rst_state", bus.dbg_state, 0);
    chk_reg("rst_pending", 2'd1, 0);
    chk_reg("rst_mask", 2'd0, 0);
    resetn = 1'b1;
    tick();

    // Latency: line rises before edge N, pending after N+2, request after N+3
    reg_wr(2'd0, 32'hF);
    chk_reg("mask_f", 2'd0, 32'hF);
    bus.src_irq = 4'b0100;
    tick();
    tick();
    chk_reg("lat_pend_n1", 2'd1, 0);
    tick();
    chk_reg("lat_pend_n2", 2'd1, 32'h4);
    check("lat_out_n2", bus.out_interruption, 0);
    tick();
    check("lat_out_n3", bus.out_interruption, 1);
    ack();
    check("ack2_active", bus.active_id, 4'hA);
    check("ack2_out", bus.out_interruption, 0);
    check("ack2_state", bus.dbg_state, 1);
    chk_reg("ack2_pend", 2'd1, 0);
    chk_reg("ack2_id", 2'd2, 32'h12);
    reg_wr(2'd3, 32'h0);
    check("eoi2_state", bus.dbg_state, 0);
    check("eoi2_active", bus.active_id, 0);
    repeat (5) tick();
    chk_reg("level_no_reset", 2'd1, 0);
    check("level_out", bus.out_interruption, 0);
    bus.src_irq = '0;
    repeat (3) tick();

    // Priority: pending 1010 -> source 1 wins
    bus.src_irq = 4'b1010;
    tick();
    bus.src_irq = '0;
    repeat (3) tick();
    chk_reg("pri_pend", 2'd1, 32'hA);
    check("pri_out", bus.out_interruption, 1);
    ack();
    check("pri_active", bus.active_id, 4'h9);
    check("pri_out_ack", bus.out_interruption, 0);
    chk_reg("pri_pend_ack", 2'd1, 32'h8);
    ack();
    check("svc_ack_active", bus.active_id, 4'h9);
    check("svc_ack_state", bus.dbg_state, 1);
    check("svc_out", bus.out_interruption, 0);
    chk_reg("svc_ack_pend", 2'd1, 32'h8);
    reg_wr(2'd0, 32'h0);
    check("mask_after_ack", bus.active_id, 4'h9);
    reg_wr(2'd0, 32'hF);
    reg_wr(2'd3, 32'h0);
    check("eoi_out_0", bus.out_interruption, 0);
    check("eoi_state", bus.dbg_state, 0);
    tick();
    check("eoi_out_1", bus.out_interruption, 1);

    // EOI and ack together in IDLE: ack ignored
    bus.reg_we   = 1'b1;
    bus.reg_addr = 2'd3;
    bus.int_ack  = 1'b1;
    tick();
    bus.reg_we   = 1'b0;
    bus.int_ack  = 1'b0;
    check("eoiack_active", bus.active_id, 0);
    check("eoiack_state", bus.dbg_state, 0);
    chk_reg("eoiack_pend", 2'd1, 32'h8);
    ack();
    check("ack3_active", bus.active_id, 4'hB);
    chk_reg("ack3_pend", 2'd1, 0);
    reg_wr(2'd3, 32'h0);
    tick();
    check("idle_out", bus.out_interruption, 0);

    // Masked pending retained, forwarded once enabled; W1C clears
    reg_wr(2'd0, 32'h0);
    bus.src_irq = 4'b0001;
    tick();
    bus.src_irq = '0;
    repeat (4) tick();
    chk_reg("masked_pend", 2'd1, 32'h1);
    check("masked_out", bus.out_interruption, 0);
    reg_wr(2'd0, 32'h1);
    check("unmask_out_0", bus.out_interruption, 0);
    tick();
    check("unmask_out_1", bus.out_interruption, 1);
    reg_wr(2'd1, 32'h1);
    chk_reg("w1c_pend", 2'd1, 0);
    tick();
    check("w1c_out", bus.out_interruption, 0);

    // Edge on source 1 in the same cycle as W1C of bit 1: set wins
    bus.src_irq = 4'b0010;
    tick();
    tick();
    bus.reg_we    = 1'b1;
    bus.reg_addr  = 2'd1;
    bus.reg_wdata = 32'h2;
    tick();
    bus.reg_we    = 1'b0;
    bus.reg_wdata = '0;
    chk_reg("setwins_pend", 2'd1, 32'h2);
    reg_wr(2'd1, 32'h2);
    chk_reg("w1c_held_pend", 2'd1, 0);
    bus.src_irq = '0;

    // Ack with nothing pending; ID write ignored; EOI reads 0
    ack();
    check("noack_active", bus.active_id, 0);
    check("noack_state", bus.dbg_state, 0);
    reg_wr(2'd2, 32'hFFFF_FFFF);
    chk_reg("idwr_mask", 2'd0, 32'h1);
    chk_reg("idwr_id", 2'd2, 0);
    chk_reg("eoi_read", 2'd3, 0);

    // Level held 100 cycles gives one pending event
    reg_wr(2'd0, 32'hF);
    bus.src_irq = 4'b1000;
    repeat (5) tick();
    chk_reg("hold_pend", 2'd1, 32'h8);
    reg_wr(2'd1, 32'h8);
    repeat (100) tick();
    chk_reg("hold_once", 2'd1, 0);
    bus.src_irq = '0;
    repeat (3) tick();

    // Service, new edge during service, then async reset
    bus.src_irq = 4'b1000;
    tick();
    bus.src_irq = '0;
    repeat (3) tick();
    check("pre_rst_out", bus.out_interruption, 1);
    ack();
    check("pre_rst_active", bus.active_id, 4'hB);
    bus.src_irq = 4'b0001;
    tick();
    bus.src_irq = '0;
    repeat (3) tick();
    chk_reg("svc_new_pend", 2'd1, 32'h1);
    check("svc_new_out", bus.out_interruption, 0);
    check("svc_new_active", bus.active_id, 4'hB);
    #3;
    resetn      = 1'b0;
    bus.src_irq = 4'b0001;
    #1;
    check("arst_out", bus.out_interruption, 0);
    check("arst_active", bus.active_id, 0);
    check("arst_state", bus.dbg_state, 0);
    chk_reg("arst_pend", 2'd1, 0);
    chk_reg("arst_mask", 2'd0, 0);
    tick();
    resetn = 1'b1;

    // Line already high at release yields exactly one edge
    repeat (4) tick();
    chk_reg("rel_pend", 2'd1, 32'h1);
    check("rel_out", bus.out_interruption, 0);
    reg_wr(2'd1, 32'h1);
    repeat (10) tick();
    chk_reg("rel_once", 2'd1, 0);
    bus.src_irq = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/int_arbiter.md
INT_ARBITER -- requirements
Module: int_arbiter

Interface
REQ-001 Parameter NSRC, default 4, number of external interrupt sources (2..8).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flops per source (>=2).
REQ-003 clk  input  1  CPU clock (clk_cpu domain); all state on rising edge.
REQ-004 resetn  input  1  asynchronous active-low reset, one clock.
REQ-005 src_irq  input  NSRC  raw asynchronous interrupt lines (buttons/pins), active-high.
REQ-006 int_ack  input  1  single-cycle acknowledge pulse from Core on interrupt entry.
REQ-007 reg_we  input  1  register write strobe from DMEM-side decode.
REQ-008 reg_addr  input  2  register select: 0 MASK, 1 PENDING, 2 ID, 3 EOI.
REQ-009 reg_wdata  input  32  write data.
REQ-010 reg_rdata  output  32  combinational read data for reg_addr.
REQ-011 out_interruption  output  1  registered interrupt request to Core, level, active-high.
REQ-012 active_id  output  4  index of source in service; bit 3 = valid.

Function
REQ-013 Each src_irq bit SHALL pass SYNC_STAGES flops, then a rising-edge detector (synced & ~previous synced).
REQ-014 Latency (SYNC_STAGES=2): src_irq high before edge N -> pending bit set after edge N+2 -> out_interruption high after edge N+3.
REQ-015 Detected edge SHALL set pending[i]; levels held high SHALL NOT re-set pending after it is cleared.
REQ-016 MASK write: mask[NSRC-1:0] <= reg_wdata[NSRC-1:0]; 1 = enabled; masked pending bits retained, not forwarded.
REQ-017 PENDING write: write-1-to-clear per bit; read returns pending zero-extended.
REQ-018 ID read: {27'b0, active_id[3], 1'b0, active_id[2:0]} — bit 4 valid, bits 2:0 index; MASK read returns mask.
REQ-019 EOI write (any data) SHALL clear in_service and active_id valid.
REQ-020 eligible = pending & mask; winner = lowest index set in eligible (fixed priority, 0 highest).
REQ-021 FSM IDLE: out_interruption <= |eligible; on int_ack with eligible nonzero -> SERVICE.
REQ-022 IDLE->SERVICE on int_ack: active_id <= {1, winner}, pending[winner] cleared, out_interruption <= 0 next edge.
REQ-023 SERVICE: out_interruption held 0 (no nesting); new edges still set pending; EOI -> IDLE, request re-evaluated next edge.
REQ-024 int_ack with eligible==0 or in SERVICE SHALL be ignored (no state change).
REQ-025 Simultaneous set and clear of one pending bit (edge vs W1C or ack): set wins, bit stays 1.
REQ-026 Simultaneous EOI write and int_ack: EOI processed, ack ignored that cycle.
REQ-027 Writes to ID address SHALL be ignored; reads of EOI return 0.
REQ-028 Winner SHALL be sampled in the ack cycle; mask changes after ack do not alter active_id.

Reset
REQ-029 resetn low asynchronously: sync flops 0, pending 0, mask 0, FSM IDLE, out_interruption 0, active_id 0.
REQ-030 Release mid-assertion of src_irq SHALL produce one edge only if line rises after release (sync chain starts at 0, so a line already high yields one edge).
REQ-031 Reset during SERVICE SHALL abandon service; no pending survives.

Verification
REQ-032 mask=0xF, src_irq[2] rises before edge 10 -> PENDING=0x4 after edge 12, out_interruption=1 after edge 13.
REQ-033 pending=0b1010, mask=0xF, int_ack -> active_id=4'b1001, PENDING=0b1000, out_interruption=0; EOI -> out_interruption=1 next edge.
REQ-034 mask=0x0, src_irq[0] pulse -> PENDING=0x1, out_interruption=0; write MASK=0x1 -> out_interruption=1 next edge.
REQ-035 Same-cycle edge on src 1 and PENDING write 0x2 -> PENDING bit1 stays 1.
REQ-036 int_ack with PENDING=0 -> active_id stays 0, FSM IDLE; src_irq held high 100 cycles -> exactly one pending set.
REQ-037 resetn low in SERVICE -> all outputs 0 immediately, without waiting for clk.
